snes_rgb_scaler: RTL and testbench

//  Parametrised PPU2 digital-RGB post-processor feeding the ADV7123 DAC path.
//  - Snoops PPU B-bus writes to INIDISP ($2100), BGMODE ($2105) and SETINI ($2133).
//  - Applies master brightness and force-blank to NCH colour channels through a fixed-latency pipeline.
//  - Optionally dims pixels under the OSD window.
//  - Exports a hi-res flag for DAC clock selection and dot/line counters for OSD placement.

---
 rtl/snes_tst_pkg.sv | 18 +
 rtl/snes_ppu_snoop.sv | 78 +++++++
 rtl/snes_rgb_scaler.sv | 126 ++++++++++++
 tb/tb_snes_rgb_scaler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/snes_tst_pkg.sv
// Shared PPU register map and helpers for the SNES RGB post-processor.
package snes_tst_pkg;

    localparam logic [7:0] ADDR_INIDISP = 8'h00;
    localparam logic [7:0] ADDR_BGMODE  = 8'h05;
    localparam logic [7:0] ADDR_SETINI  = 8'h33;
    localparam logic [3:0] BRIGHT_RST   = 4'hF;

    typedef struct packed {
        logic [3:0] bright;
        logic       fblank;
    } inidisp_t;

    function automatic logic hires_dec(input logic [2:0] mode, input logic pseudo);
        return (mode == 3'd5) || (mode == 3'd6) || (pseudo && (mode <= 3'd4));
    endfunction

endpackage

// File: rtl/snes_ppu_snoop.sv
// B-bus write snooper: synchronises the PPU write strobe and keeps the
// staged/active INIDISP copy plus BGMODE/SETINI-derived mode flags.
module snes_ppu_snoop
    import snes_tst_pkg::*;
#(
    parameter int LINE_SYNC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pawr_n,
    input  logic [7:0] paddr,
    input  logic [7:0] pdata,
    input  logic       hblank,
    input  logic       vblank,
    output logic [3:0] bright,
    output logic       fblank,
    output logic       hires,
    output logic       mode7
);

    logic     pawr_s1, pawr_s2, pawr_d;
    logic     hblank_d;
    logic     wr, wr_ini, hblank_rise;
    inidisp_t staged, active, ini_wdata;
    logic [2:0] bgmode, bgmode_nxt;
    logic       pseudo, pseudo_nxt;
    logic       unused_pdata;

    // Falling edge of the synchronised strobe: a held-low level fires only once.
    assign wr          = pawr_d & ~pawr_s2;
    assign wr_ini      = wr && (paddr == ADDR_INIDISP);
    assign hblank_rise = hblank & ~hblank_d;
    assign ini_wdata   = inidisp_t'{bright: pdata[3:0], fblank: pdata[7]};
    assign unused_pdata = ^pdata[6:4];

    always_comb begin
        bgmode_nxt = bgmode;
        pseudo_nxt = pseudo;
        if (wr && (paddr == ADDR_BGMODE)) bgmode_nxt = pdata[2:0];
        if (wr && (paddr == ADDR_SETINI)) pseudo_nxt = pdata[3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pawr_s1  <= 1'b1;
            pawr_s2  <= 1'b1;
            pawr_d   <= 1'b1;
            hblank_d <= 1'b0;
            staged   <= inidisp_t'{bright: BRIGHT_RST, fblank: 1'b0};
            active   <= inidisp_t'{bright: BRIGHT_RST, fblank: 1'b0};
            bgmode   <= 3'd0;
            pseudo   <= 1'b0;
            hires    <= 1'b0;
            mode7    <= 1'b0;
        end else begin
            pawr_s1  <= pawr_n;
            pawr_s2  <= pawr_s1;
            pawr_d   <= pawr_s2;
            hblank_d <= hblank;
            bgmode   <= bgmode_nxt;
            pseudo   <= pseudo_nxt;
            hires    <= hires_dec(bgmode_nxt, pseudo_nxt);
            mode7    <= (bgmode_nxt == 3'd7);
            if (wr_ini) staged <= ini_wdata;
            // A write landing on the HBLANK edge itself is only staged here;
            // the copy below still sees the previous staged value.
            if (LINE_SYNC == 0) begin
                if (wr_ini) active <= ini_wdata;
            end else if (vblank || hblank_rise) begin
                active <= staged;
            end
        end
    end

    assign bright = active.bright;
    assign fblank = active.fblank;

endmodule

// File: rtl/snes_rgb_scaler.sv
// PPU2 digital-RGB post-processor: brightness/force-blank/OSD dimming in a
// 3-stage pixel pipe, plus hi-res detection and dot/line counters.
module snes_rgb_scaler
    import snes_tst_pkg::*;
#(
    parameter int NCH       = 3,
    parameter int IN_W      = 5,
    parameter int OUT_W     = 9,
    parameter int OSD_SHIFT = 2,
    parameter int LINE_SYNC = 1,
    parameter int DOT_DIV   = 4,
    parameter int H_TOTAL   = 340
) (
    input  logic                 CLK_i,
    input  logic                 NRST_i,
    input  logic                 PAWR_n_i,
    input  logic [7:0]           PADDR_i,
    input  logic [7:0]           PDATA_i,
    input  logic                 HBLANK_i,
    input  logic                 VBLANK_i,
    input  logic                 OSD_ACT_i,
    input  logic [NCH*IN_W-1:0]  RGB_i,
    output logic [NCH*OUT_W-1:0] RGB_o,
    output logic                 BLANK_o,
    output logic                 HIRES_o,
    output logic                 MODE7_o,
    output logic [8:0]           HCNT_o,
    output logic [8:0]           VCNT_o
);

    localparam int PW    = IN_W + 4;
    localparam int DIV_W = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;

    generate
        if (OUT_W > IN_W + 4) begin : g_width_check
            $error("snes_rgb_scaler: OUT_W must not exceed IN_W+4");
        end
    endgenerate

    logic [3:0] bright;
    logic       fblank;

    snes_ppu_snoop #(
        .LINE_SYNC (LINE_SYNC)
    ) u_snoop (
        .clk    (CLK_i),
        .rst_n  (NRST_i),
        .pawr_n (PAWR_n_i),
        .paddr  (PADDR_i),
        .pdata  (PDATA_i),
        .hblank (HBLANK_i),
        .vblank (VBLANK_i),
        .bright (bright),
        .fblank (fblank),
        .hires  (HIRES_o),
        .mode7  (MODE7_o)
    );

    logic [NCH*IN_W-1:0]  rgb_s1;
    logic                 osd_s1, blank_s1, blank_s2;
    logic [NCH*PW-1:0]    prod_nxt, prod_s2;
    logic [NCH*OUT_W-1:0] rgb_nxt;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic [IN_W-1:0] pix, pix_sel;
            assign pix     = rgb_s1[c*IN_W +: IN_W];
            assign pix_sel = osd_s1 ? (pix >> OSD_SHIFT) : pix;
            // Full-width product: 31*15 fits in IN_W+4 bits, so no clamp needed.
            assign prod_nxt[c*PW +: PW] = {4'b0, pix_sel} * {{IN_W{1'b0}}, bright};
            assign rgb_nxt[c*OUT_W +: OUT_W] =
                blank_s2 ? '0 : prod_s2[c*PW + PW - 1 -: OUT_W];
        end
    endgenerate

    always_ff @(posedge CLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            rgb_s1   <= '0;
            osd_s1   <= 1'b0;
            blank_s1 <= 1'b1;
            prod_s2  <= '0;
            blank_s2 <= 1'b1;
            RGB_o    <= '0;
            BLANK_o  <= 1'b1;
        end else begin
            rgb_s1   <= RGB_i;
            osd_s1   <= OSD_ACT_i;
            blank_s1 <= fblank | HBLANK_i | VBLANK_i;
            prod_s2  <= prod_nxt;
            blank_s2 <= blank_s1;
            RGB_o    <= rgb_nxt;
            BLANK_o  <= blank_s2;
        end
    end

    logic [DIV_W-1:0] div_cnt;
    logic             dot_tc;

    // Dot divider runs as a down-counter; terminal count marks one dot.
    assign dot_tc = (div_cnt == '0);

    always_ff @(posedge CLK_i or negedge NRST_i) begin
        if (!NRST_i) begin
            div_cnt <= DIV_W'(DOT_DIV - 1);
            HCNT_o  <= 9'd0;
            VCNT_o  <= 9'd0;
        end else if (VBLANK_i) begin
            div_cnt <= DIV_W'(DOT_DIV - 1);
            HCNT_o  <= 9'd0;
            VCNT_o  <= 9'd0;
        end else begin
            div_cnt <= dot_tc ? DIV_W'(DOT_DIV - 1) : div_cnt - 1'b1;
            if (HBLANK_i && (HCNT_o == 9'd0)) begin
                HCNT_o <= 9'd0;
            end else if (dot_tc) begin
                if (HCNT_o == 9'(H_TOTAL - 1)) begin
                    HCNT_o <= 9'd0;
                    if (VCNT_o != 9'd511) VCNT_o <= VCNT_o + 9'd1;
                end else begin
                    HCNT_o <= HCNT_o + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snes_rgb_scaler.sv
// Directed bench for snes_rgb_scaler with hand-computed expected values.
module tb_snes_rgb_scaler;

    logic        CLK_i = 1'b0;
    logic        NRST_i;
    logic        PAWR_n_i;
    logic [7:0]  PADDR_i, PDATA_i;
    logic        HBLANK_i, VBLANK_i, OSD_ACT_i;
    logic [14:0] RGB_i;
    logic [26:0] RGB_o;
    logic        BLANK_o, HIRES_o, MODE7_o;
    logic [8:0]  HCNT_o, VCNT_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [14:0] PIX_1F  = {3{5'h1F}};
    localparam logic [14:0] PIX_20  = {3{5'd20}};
    localparam logic [26:0] OUT_465 = {3{9'd465}};
    localparam logic [26:0] OUT_248 = {3{9'd248}};
    localparam logic [26:0] OUT_75  = {3{9'd75}};

    snes_rgb_scaler dut (
        .CLK_i     (CLK_i),
        .NRST_i    (NRST_i),
        .PAWR_n_i  (PAWR_n_i),
        .PADDR_i   (PADDR_i),
        .PDATA_i   (PDATA_i),
        .HBLANK_i  (HBLANK_i),
        .VBLANK_i  (VBLANK_i),
        .OSD_ACT_i (OSD_ACT_i),
        .RGB_i     (RGB_i),
        .RGB_o     (RGB_o),
        .BLANK_o   (BLANK_o),
        .HIRES_o   (HIRES_o),
        .MODE7_o   (MODE7_o),
        .HCNT_o    (HCNT_o),
        .VCNT_o    (VCNT_o)
    );

    always #5 CLK_i = ~CLK_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_i);
        #1;
    endtask

    task automatic ppu_wr(input logic [7:0] a, input logic [7:0] d, input int low_cyc);
        PADDR_i  = a;
        PDATA_i  = d;
        PAWR_n_i = 1'b0;
        tick(low_cyc);
        PAWR_n_i = 1'b1;
        tick(4);
    endtask

    task automatic hblank_pulse();
        HBLANK_i = 1'b1;
        tick(3);
        HBLANK_i = 1'b0;
        tick(4);
    endtask

    initial begin
        NRST_i    = 1'b0;
        PAWR_n_i  = 1'b1;
        PADDR_i   = 8'h00;
        PDATA_i   = 8'h00;
        HBLANK_i  = 1'b0;
        VBLANK_i  = 1'b0;
        OSD_ACT_i = 1'b0;
        RGB_i     = PIX_1F;
        tick(3);

        chk("rst_rgb",   32'(RGB_o),   32'd0);
        chk("rst_blank", 32'(BLANK_o), 32'd1);
        chk("rst_hires", 32'(HIRES_o), 32'd0);
        chk("rst_mode7", 32'(MODE7_o), 32'd0);
        chk("rst_hcnt",  32'(HCNT_o),  32'd0);

        // Test 1: default brightness 15 on full-scale input.
        NRST_i = 1'b1;
        tick(3);
        chk("t1_rgb",   32'(RGB_o),   32'(OUT_465));
        chk("t1_blank", 32'(BLANK_o), 32'd0);
        chk("t1_hires", 32'(HIRES_o), 32'd0);

        // Test 2: brightness 8 staged until HBLANK rise.
        ppu_wr(8'h00, 8'h08, 5);
        chk("t2_staged", 32'(RGB_o), 32'(OUT_465));
        tick(10);
        chk("t2_still", 32'(RGB_o), 32'(OUT_465));
        HBLANK_i = 1'b1;
        tick(4);
        chk("t2_hb_blank", 32'(BLANK_o), 32'd1);
        chk("t2_hb_rgb",   32'(RGB_o),   32'd0);
        HBLANK_i = 1'b0;
        tick(4);
        chk("t2_rgb", 32'(RGB_o), 32'(OUT_248));

        // Test 3: force-blank then restore.
        ppu_wr(8'h00, 8'h8F, 5);
        chk("t3_pre", 32'(RGB_o), 32'(OUT_248));
        hblank_pulse();
        chk("t3_fb_blank", 32'(BLANK_o), 32'd1);
        chk("t3_fb_rgb",   32'(RGB_o),   32'd0);
        ppu_wr(8'h00, 8'h0F, 5);
        hblank_pulse();
        chk("t3_rest_blank", 32'(BLANK_o), 32'd0);
        chk("t3_rest_rgb",   32'(RGB_o),   32'(OUT_465));

        // Brightness 0: black but not flagged blank.
        ppu_wr(8'h00, 8'h00, 5);
        hblank_pulse();
        chk("b0_rgb",   32'(RGB_o),   32'd0);
        chk("b0_blank", 32'(BLANK_o), 32'd0);
        ppu_wr(8'h00, 8'h0F, 5);
        hblank_pulse();
        chk("b15_rgb", 32'(RGB_o), 32'(OUT_465));

        // Test 5: OSD dimming, 20>>2 = 5, *15 = 75, three clocks latency.
        @(negedge CLK_i);
        OSD_ACT_i = 1'b1;
        RGB_i     = PIX_20;
        tick(2);
        chk("t5_lat2", 32'(RGB_o), 32'(OUT_465));
        tick(1);
        chk("t5_lat3", 32'(RGB_o), 32'(OUT_75));
        OSD_ACT_i = 1'b0;
        RGB_i     = PIX_1F;
        tick(3);

        // Test 4: mode decode, ignored address, single capture on long strobe.
        ppu_wr(8'h05, 8'h01, 5);
        ppu_wr(8'h33, 8'h08, 5);
        chk("t4_hires_m1p", 32'(HIRES_o), 32'd1);
        chk("t4_mode7_m1p", 32'(MODE7_o), 32'd0);
        ppu_wr(8'h05, 8'h07, 5);
        chk("t4_hires_m7", 32'(HIRES_o), 32'd0);
        chk("t4_mode7_m7", 32'(MODE7_o), 32'd1);
        ppu_wr(8'h06, 8'h05, 5);
        chk("t4_ignored", 32'(MODE7_o), 32'd1);
        PADDR_i  = 8'h05;
        PDATA_i  = 8'h05;
        PAWR_n_i = 1'b0;
        tick(6);
        chk("t4_long_m5", 32'(HIRES_o), 32'd1);
        PDATA_i = 8'h07;
        tick(14);
        PAWR_n_i = 1'b1;
        tick(4);
        chk("t4_single_hires", 32'(HIRES_o), 32'd1);
        chk("t4_single_mode7", 32'(MODE7_o), 32'd0);

        // Test 6: counters after VBLANK fall.
        VBLANK_i = 1'b1;
        tick(5);
        chk("t6_vb_hcnt", 32'(HCNT_o), 32'd0);
        chk("t6_vb_vcnt", 32'(VCNT_o), 32'd0);
        VBLANK_i = 1'b0;
        tick(4);
        chk("t6_first_dot", 32'(HCNT_o), 32'd1);
        tick(4 * 338);
        chk("t6_h339", 32'(HCNT_o), 32'd339);
        chk("t6_v0",   32'(VCNT_o), 32'd0);
        tick(4);
        chk("t6_hwrap", 32'(HCNT_o), 32'd0);
        chk("t6_v1",    32'(VCNT_o), 32'd1);
        HBLANK_i = 1'b1;
        tick(12);
        chk("t6_realign", 32'(HCNT_o), 32'd0);
        HBLANK_i = 1'b0;
        tick(4 * 5);
        chk("t6_h5", 32'(HCNT_o), 32'd5);
        chk("t6_pre_rst_rgb", 32'(RGB_o), 32'(OUT_465));

        // Asynchronous reset mid-line.
        #2;
        NRST_i = 1'b0;
        #1;
        chk("ar_rgb",   32'(RGB_o),   32'd0);
        chk("ar_blank", 32'(BLANK_o), 32'd1);
        chk("ar_hires", 32'(HIRES_o), 32'd0);
        chk("ar_mode7", 32'(MODE7_o), 32'd0);
        chk("ar_hcnt",  32'(HCNT_o),  32'd0);
        chk("ar_vcnt",  32'(VCNT_o),  32'd0);
        tick(2);
        NRST_i = 1'b1;
        tick(2);
        chk("ar_refill2", 32'(BLANK_o), 32'd1);
        tick(1);
        chk("ar_refill3", 32'(RGB_o), 32'(OUT_465));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
